coproc_io_sequencer: RTL
========================

# coproc_io_sequencer

Sequences debug-host accesses onto the datapath coprocessor I/O port: `coprocessorIOAddr`, `coprocessorIOControl`, `coprocessorIODataOut` and `coprocessorIODataIn`. It halts and resumes the core, single-steps it, and performs GPR/CSR reads and writes while the core is halted. It also auto-halts on a datapath break (`breakSrc`). It sits between the host-link front end and `datapath`, and is the only driver of the coprocessor I/O port.

## Interface
- `N`, default 64: datapath word width.
- `clk`  in  1: clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: host request valid.
- `req_ready`  out  1: sequencer accepts a request. A request transfers when `req_valid` and `req_ready` are both high.
- `req_op`  in  3: operation code.
  - 0 READ_GPR, 1 WRITE_GPR, 2 READ_CSR, 3 WRITE_CSR
  - 4 HALT, 5 RESUME, 6 STEP, 7 STATUS
- `req_addr`  in  12: GPR index in [4:0], or CSR address.
- `req_wdata`  in  N: write data.
- `rsp_valid`  out  1: response valid; held until `rsp_ready`.
- `rsp_ready`  in  1: host consumes the response.
- `rsp_data`  out  N: read data or status word.
- `rsp_err`  out  1: request rejected.
- `breakSrc`  in  2: datapath break sources.
- `coprocessorIODataIn`  in  N: register/CSR read data from the datapath.
- `coprocessorIOAddr`  out  15: access address.
- `coprocessorIOControl`  out  5: control bits.
  - [0] GPR write enable, [1] read strobe, [2] halt, [3] CSR select, [4] CSR write enable.
  - Any nonzero value stalls the PC.
- `coprocessorIODataOut`  out  N: write data to the datapath.
- `halted`  out  1: core is halted.
- `halt_cause`  out  2: 0 none, 1 host, 2 break, 3 step.

## Operation
- States: RUN, HALTED, ACCESS, STEP, RESP.
- RUN: control = 0.
  - HALT -> HALTED; cause = host.
  - `breakSrc` != 0 with no request -> HALTED; cause = break; no response is generated.
  - RESUME and STATUS -> ok.
  - Access ops and STEP -> `rsp_err` = 1.
- HALTED: control = 5'b00100.
  - Access op -> ACCESS.
  - STEP -> STEP.
  - RESUME -> RUN.
  - HALT and STATUS -> ok; state is unchanged.
- ACCESS: one cycle, with control[2] kept at 1.
  - READ_GPR: addr = {10'b0, req_addr[4:0]}; control = 00110.
  - READ_CSR: addr = {3'b0, req_addr}; control = 01110.
  - WRITE_GPR: control = 00101; DataOut = `req_wdata`.
  - WRITE_CSR: control = 11100; DataOut = `req_wdata`.
  - Reads capture `coprocessorIODataIn` at the end of the ACCESS cycle.
  - Then -> HALTED, with the response pending.
- READ_GPR/WRITE_GPR with `req_addr[11:5]` != 0 -> `rsp_err`; the datapath is not touched.
- A write to x0 is issued normally and responds ok; the register file ignores it.
- STEP: control = 0 for exactly one cycle, so one instruction retires. Then -> HALTED; cause = step.
  - If `breakSrc` != 0 during the STEP cycle, cause = break.
- STATUS: `rsp_data` = {N-3 zeros, `halt_cause`, `halted`}.
- Responses:
  - `rsp_data` = 0 for writes and errors.
  - `rsp_valid` stays high until `rsp_ready`.
  - `req_ready` = 0 while a response is pending, or in ACCESS/STEP. One request is outstanding at a time.
- Both `req_ready` and `rsp_valid` are held low in ACCESS and STEP.
- `breakSrc` is ignored in HALTED, ACCESS and RESP.
- A HALT accepted in the same cycle that `breakSrc` != 0: cause = break, and the HALT responds ok.
- `coprocessorIOAddr` and `coprocessorIODataOut` are 0 outside ACCESS.

## Timing
- All outputs are registered.
- Reset (async, active-low): state RUN, control 0, addr 0, DataOut 0, `rsp_valid` 0, `rsp_err` 0, `rsp_data` 0, `halted` 0, `halt_cause` 0, `req_ready` 1.
- Reset asserted mid-ACCESS/STEP aborts the operation; no response is issued.
- Request accepted at edge T; cycle counts below are relative to T.
  - HALT/RESUME/STATUS/errors: `rsp_valid` from T+1; state/control update at T+1.
  - READ/WRITE: ACCESS drives the port during T+1; `rsp_valid` from T+2.
  - STEP: control 0 during T+1; control 00100 and `rsp_valid` from T+2.
- Response consumed at edge R (`rsp_valid` and `rsp_ready` both high) -> `rsp_valid` = 0 and `req_ready` = 1 from R+1.
- Auto-halt: `breakSrc` != 0 sampled at edge B -> `halted` = 1 and control = 00100 from B+1.
- `halted` is 1 whenever state ∉ {RUN, STEP}.

## Test plan
- Reset, then HALT: control = 00100 and `halted` = 1 at T+1. STATUS then returns `rsp_data` = 3 (cause host, halted).
- Halted; WRITE_GPR addr 5, data 64'hDEAD_BEEF: control = 00101 for one cycle. READ_GPR 5 then returns 64'hDEAD_BEEF at T+2.
- Halted; READ_CSR 12'h341: addr = 15'h0341, control = 01110 for one cycle. `rsp_data` equals the `coprocessorIODataIn` value sampled in that cycle.
- Running; READ_GPR 3 -> `rsp_err` = 1 at T+1 and control stays 0. With halted, READ_GPR addr 12'h040 -> `rsp_err` = 1.
- Halted; STEP: control = 0 for exactly one cycle, then 00100. `halt_cause` = 3; with `breakSrc` = 2'b01 in the STEP cycle, `halt_cause` = 2.
- Running; `breakSrc` = 2'b10 -> `halted` = 1 next cycle and cause = 2. Assert reset during a following ACCESS cycle -> all outputs return to reset values with no response.

Source files
------------

// File: rtl/coproc_io_sequencer.sv
// ---------------------------------------------------------------------------
// coproc_io_sequencer
//
// Sequences debug-host requests onto the datapath coprocessor I/O port. It
// halts, resumes and single-steps the core. While the core is halted it
// performs GPR/CSR reads and writes. A datapath break (breakSrc) seen while
// running halts the core automatically. This block is the only driver of the
// coprocessor I/O port.
//
// Ports
//   clk, reset                : clock; asynchronous active-low reset
//   req_valid/req_ready       : host request handshake
//   req_op, req_addr          : operation code; GPR index [4:0] or CSR address
//   req_wdata                 : write data for WRITE_GPR / WRITE_CSR
//   rsp_valid/rsp_ready       : response handshake (valid held until ready)
//   rsp_data, rsp_err         : read data or status word; request rejected
//   breakSrc                  : datapath break sources
//   coprocessorIODataIn       : register/CSR read data from the datapath
//   coprocessorIOAddr         : access address (zero outside an access)
//   coprocessorIOControl      : [0] GPR we, [1] read, [2] halt, [3] CSR sel,
//                               [4] CSR we
//   coprocessorIODataOut      : write data (zero outside an access)
//   halted, halt_cause        : core halted; 0 none, 1 host, 2 break, 3 step
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module coproc_io_sequencer #(
    parameter int N = 64
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [2:0]     req_op,
    input  logic [11:0]    req_addr,
    input  logic [N-1:0]   req_wdata,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [N-1:0]   rsp_data,
    output logic           rsp_err,
    input  logic [1:0]     breakSrc,
    input  logic [N-1:0]   coprocessorIODataIn,
    output logic [14:0]    coprocessorIOAddr,
    output logic [4:0]     coprocessorIOControl,
    output logic [N-1:0]   coprocessorIODataOut,
    output logic           halted,
    output logic [1:0]     halt_cause
);

    typedef enum logic [2:0] {
        S_RUN,
        S_HALTED,
        S_ACCESS,
        S_STEP,
        S_RESP      // halted, with a response waiting for the host
    } state_t;

    localparam logic [2:0] OP_READ_GPR  = 3'd0;
    localparam logic [2:0] OP_WRITE_GPR = 3'd1;
    localparam logic [2:0] OP_READ_CSR  = 3'd2;
    localparam logic [2:0] OP_WRITE_CSR = 3'd3;
    localparam logic [2:0] OP_HALT      = 3'd4;
    localparam logic [2:0] OP_RESUME    = 3'd5;
    localparam logic [2:0] OP_STEP      = 3'd6;
    localparam logic [2:0] OP_STATUS    = 3'd7;

    localparam logic [4:0] CTRL_RUN       = 5'b00000;
    localparam logic [4:0] CTRL_HALT      = 5'b00100;
    localparam logic [4:0] CTRL_READ_GPR  = 5'b00110;
    localparam logic [4:0] CTRL_WRITE_GPR = 5'b00101;
    localparam logic [4:0] CTRL_READ_CSR  = 5'b01110;
    localparam logic [4:0] CTRL_WRITE_CSR = 5'b11100;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_HOST  = 2'd1;
    localparam logic [1:0] CAUSE_BREAK = 2'd2;
    localparam logic [1:0] CAUSE_STEP  = 2'd3;

    state_t         state_q, state_n;
    logic [4:0]     ctrl_q, ctrl_n, acc_ctrl;
    logic [14:0]    addr_q, addr_n;
    logic [N-1:0]   dout_q, dout_n;
    logic           rsp_valid_q, rsp_valid_n;
    logic           rsp_err_q, rsp_err_n;
    logic [N-1:0]   rsp_data_q, rsp_data_n;
    logic [1:0]     cause_q, cause_n;
    logic           halted_q, halted_n;
    logic           req_ready_q, req_ready_n;
    logic           is_read_q, is_read_n;

    logic           accept;
    logic           brk;
    logic           range_err;
    logic [N-1:0]   status_word;
    logic           issue;
    logic           issue_err;
    logic [N-1:0]   issue_data;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statements can leave one unassigned (no latches).
    always_comb begin
        accept      = req_valid && req_ready_q;
        brk         = (breakSrc != 2'b00);
        // GPR ops only address x0..x31; higher address bits must be clear.
        range_err   = !req_op[1] && (req_addr[11:5] != 7'd0);
        status_word = {{(N-3){1'b0}}, cause_q, halted_q};

        state_n     = state_q;
        addr_n      = '0;
        dout_n      = '0;
        acc_ctrl    = CTRL_HALT;
        is_read_n   = is_read_q;
        cause_n     = cause_q;
        issue       = 1'b0;
        issue_err   = 1'b0;
        issue_data  = '0;

        // A pending response is retired by rsp_ready; data/err clear with it.
        rsp_valid_n = rsp_valid_q && !rsp_ready;
        rsp_err_n   = rsp_valid_n ? rsp_err_q  : 1'b0;
        rsp_data_n  = rsp_valid_n ? rsp_data_q : '0;

        unique case (state_q)
            S_RUN: begin
                if (accept) begin
                    issue = 1'b1;
                    case (req_op)
                        OP_HALT: begin
                            state_n = S_RESP;
                            // A break in the same cycle wins over the host.
                            cause_n = brk ? CAUSE_BREAK : CAUSE_HOST;
                        end
                        OP_RESUME: cause_n    = CAUSE_NONE;
                        OP_STATUS: issue_data = status_word;
                        default:   issue_err  = 1'b1;
                    endcase
                end else if (brk) begin
                    // Auto-halt: no response. A response still owed to the
                    // host for an earlier request keeps the RESP hold.
                    cause_n = CAUSE_BREAK;
                    state_n = rsp_valid_n ? S_RESP : S_HALTED;
                end
            end

            S_HALTED: begin
                if (accept) begin
                    if (!req_op[2]) begin
                        if (range_err) begin
                            issue     = 1'b1;
                            issue_err = 1'b1;
                            state_n   = S_RESP;
                        end else begin
                            state_n   = S_ACCESS;
                            is_read_n = !req_op[0];
                            addr_n    = req_op[1] ? {3'b000, req_addr}
                                                  : {10'd0, req_addr[4:0]};
                            dout_n    = req_op[0] ? req_wdata : '0;
                            case (req_op[1:0])
                                OP_READ_GPR[1:0]:  acc_ctrl = CTRL_READ_GPR;
                                OP_WRITE_GPR[1:0]: acc_ctrl = CTRL_WRITE_GPR;
                                OP_READ_CSR[1:0]:  acc_ctrl = CTRL_READ_CSR;
                                default:           acc_ctrl = CTRL_WRITE_CSR;
                            endcase
                        end
                    end else begin
                        case (req_op)
                            OP_STEP: state_n = S_STEP;
                            OP_RESUME: begin
                                issue   = 1'b1;
                                state_n = S_RUN;
                                cause_n = CAUSE_NONE;
                            end
                            default: begin   // HALT, STATUS
                                issue      = 1'b1;
                                state_n    = S_RESP;
                                issue_data = (req_op == OP_STATUS) ? status_word : '0;
                            end
                        endcase
                    end
                end
            end

            S_ACCESS: begin
                // Read data is captured at the end of the single access cycle.
                issue      = 1'b1;
                issue_data = is_read_q ? coprocessorIODataIn : '0;
                state_n    = S_RESP;
            end

            S_STEP: begin
                issue   = 1'b1;
                cause_n = brk ? CAUSE_BREAK : CAUSE_STEP;
                state_n = S_RESP;
            end

            S_RESP: begin
                if (!rsp_valid_n) state_n = S_HALTED;
            end

            default: state_n = S_RUN;
        endcase

        if (issue) begin
            rsp_valid_n = 1'b1;
            rsp_err_n   = issue_err;
            rsp_data_n  = issue_data;
        end

        // Control follows the state being entered so it is valid from the
        // first cycle of that state.
        unique case (state_n)
            S_ACCESS:         ctrl_n = acc_ctrl;
            S_HALTED, S_RESP: ctrl_n = CTRL_HALT;
            default:          ctrl_n = CTRL_RUN;
        endcase

        halted_n    = !(state_n == S_RUN || state_n == S_STEP);
        req_ready_n = (state_n == S_RUN || state_n == S_HALTED) && !rsp_valid_n;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values settled before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_RUN;
            ctrl_q      <= CTRL_RUN;
            addr_q      <= '0;
            dout_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            cause_q     <= CAUSE_NONE;
            halted_q    <= 1'b0;
            req_ready_q <= 1'b1;
            is_read_q   <= 1'b0;
        end else begin
            state_q     <= state_n;
            ctrl_q      <= ctrl_n;
            addr_q      <= addr_n;
            dout_q      <= dout_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_err_q   <= rsp_err_n;
            rsp_data_q  <= rsp_data_n;
            cause_q     <= cause_n;
            halted_q    <= halted_n;
            req_ready_q <= req_ready_n;
            is_read_q   <= is_read_n;
        end
    end

    assign req_ready            = req_ready_q;
    assign rsp_valid            = rsp_valid_q;
    assign rsp_err              = rsp_err_q;
    assign rsp_data             = rsp_data_q;
    assign coprocessorIOAddr    = addr_q;
    assign coprocessorIOControl = ctrl_q;
    assign coprocessorIODataOut = dout_q;
    assign halted               = halted_q;
    assign halt_cause           = cause_q;

endmodule
